// File: rtl/dcache_mshr.sv
// dcache_mshr -- Miss Status Holding Register file between the D-cache and
// the memory arbiter.
//
// Block misses from the D-cache are allocated into free entries. They are
// issued to memory in allocation order through a small FIFO of entry indices.
// Each entry then waits for its tagged response and returns that response to
// the D-cache as a one-cycle fill pulse. Responses may come back out of order.
//
// Build option:
//   DCACHE_MSHR_MERGE_EN  when defined, a miss to a block that is already
//                         outstanding merges into the existing entry. When
//                         undefined, every accepted miss allocates its own
//                         entry and memory request.
//
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous active-low reset
//   miss_valid/addr   block miss from the D-cache
//   miss_ready        miss accepted this cycle when miss_valid is also high
//   mem_req_valid     request pending toward the arbiter (FIFO head)
//   mem_req_addr      block address of the pending request
//   mem_req_accepted  arbiter grant; only effective with a non-zero tag
//   current_req_tag   tag assigned to the granted request (same cycle)
//   mem_data          response data
//   mem_data_tag      response tag, 0 = no response
//   fill_valid        one-cycle fill pulse to the D-cache
//   fill_addr/data    block address and data of the fill
//   mshr_count        number of occupied entries
module dcache_mshr #(
    parameter int MSHR_DEPTH = 4,
    parameter int BADDR_BITS = 29,
    parameter int TAG_BITS   = 4,
    parameter int BLOCK_BITS = 64,
    localparam int IDX_W     = $clog2(MSHR_DEPTH),
    localparam int CNT_W     = $clog2(MSHR_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [BADDR_BITS-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  mem_req_valid,
    output logic [BADDR_BITS-1:0] mem_req_addr,
    input  logic                  mem_req_accepted,
    input  logic [TAG_BITS-1:0]   current_req_tag,
    input  logic [BLOCK_BITS-1:0] mem_data,
    input  logic [TAG_BITS-1:0]   mem_data_tag,
    output logic                  fill_valid,
    output logic [BADDR_BITS-1:0] fill_addr,
    output logic [BLOCK_BITS-1:0] fill_data,
    output logic [CNT_W-1:0]      mshr_count
);

    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_ISSUE = 2'd1,
        WAIT_DATA  = 2'd2
    } entry_state_t;

    entry_state_t                  entry_state [MSHR_DEPTH];
    entry_state_t                  state_next  [MSHR_DEPTH];
    logic [BADDR_BITS-1:0]         entry_addr  [MSHR_DEPTH];
    logic [TAG_BITS-1:0]           entry_tag   [MSHR_DEPTH];

    logic [IDX_W-1:0]              fifo_mem    [MSHR_DEPTH];
    logic [PTR_W-1:0]              rd_ptr;
    logic [PTR_W-1:0]              wr_ptr;
    logic                          fifo_empty;
    logic [IDX_W-1:0]              head_idx;

    logic                          merge_hit;
    logic [IDX_W-1:0]              alloc_idx;
    logic                          do_alloc;
    logic                          do_issue;
    logic                          resp_vld_p0;
    logic [IDX_W-1:0]              resp_idx_p0;

    // Request side: allocation, merge detection and issue (from registered state)
    always_comb begin
        merge_hit = 1'b0;
        alloc_idx = '0;
`ifdef DCACHE_MSHR_MERGE_EN
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (entry_state[i] != FREE && entry_addr[i] == miss_addr)
                merge_hit = 1'b1;
        end
`endif
        // Descending scan so the last hit taken is the lowest free index.
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (entry_state[i] == FREE)
                alloc_idx = IDX_W'(i);
        end
    end

    // Entries freed this cycle are not yet visible in mshr_count, so they
    // cannot be reused until the next cycle.
    assign miss_ready    = reset && ((mshr_count < CNT_W'(MSHR_DEPTH)) || merge_hit);
    assign do_alloc      = miss_valid && miss_ready && !merge_hit;

    assign fifo_empty    = (rd_ptr == wr_ptr);
    assign head_idx      = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign mem_req_valid = !fifo_empty;
    assign mem_req_addr  = entry_addr[head_idx];
    // A grant carrying tag 0 is not a real grant; the head stays and retries.
    assign do_issue      = mem_req_valid && mem_req_accepted && (current_req_tag != '0);

    // Response side: tag match against entries already waiting for data
    always_comb begin
        resp_vld_p0 = 1'b0;
        resp_idx_p0 = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (mem_data_tag != '0 && entry_state[i] == WAIT_DATA &&
                entry_tag[i] == mem_data_tag) begin
                resp_vld_p0 = 1'b1;
                resp_idx_p0 = IDX_W'(i);
            end
        end
    end

    // Entry next state. Allocate, issue and free always touch distinct
    // entries (FREE, WAIT_ISSUE and WAIT_DATA respectively).
    always_comb begin
        for (int i = 0; i < MSHR_DEPTH; i++)
            state_next[i] = entry_state[i];
        if (do_alloc)
            state_next[alloc_idx] = WAIT_ISSUE;
        if (do_issue)
            state_next[head_idx] = WAIT_DATA;
        if (resp_vld_p0)
            state_next[resp_idx_p0] = FREE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++)
                entry_state[i] <= FREE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            mshr_count <= '0;
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++)
                entry_state[i] <= state_next[i];
            if (do_alloc)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_issue)
                rd_ptr <= rd_ptr + PTR_W'(1);
            mshr_count <= mshr_count + CNT_W'(do_alloc) - CNT_W'(resp_vld_p0);
        end
    end

    // Entry payload and FIFO storage; only meaningful alongside a live state
    always_ff @(posedge clock) begin
        if (do_alloc) begin
            entry_addr[alloc_idx]            <= miss_addr;
            fifo_mem[wr_ptr[IDX_W-1:0]]      <= alloc_idx;
        end
        if (do_issue)
            entry_tag[head_idx] <= current_req_tag;
    end

    // Fill stage: one cycle after the matching response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
        end else begin
            fill_valid <= resp_vld_p0;
            if (resp_vld_p0) begin
                fill_addr <= entry_addr[resp_idx_p0];
                fill_data <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
module tb_dcache_mshr;

    localparam int MSHR_DEPTH = 4;
    localparam int BADDR_BITS = 29;
    localparam int TAG_BITS   = 4;
    localparam int BLOCK_BITS = 64;
    localparam int CNT_W      = $clog2(MSHR_DEPTH + 1);

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  miss_valid;
    logic [BADDR_BITS-1:0] miss_addr;
    logic                  miss_ready;
    logic                  mem_req_valid;
    logic [BADDR_BITS-1:0] mem_req_addr;
    logic                  mem_req_accepted;
    logic [TAG_BITS-1:0]   current_req_tag;
    logic [BLOCK_BITS-1:0] mem_data;
    logic [TAG_BITS-1:0]   mem_data_tag;
    logic                  fill_valid;
    logic [BADDR_BITS-1:0] fill_addr;
    logic [BLOCK_BITS-1:0] fill_data;
    logic [CNT_W-1:0]      mshr_count;

    int errors = 0;
    int checks = 0;

    dcache_mshr #(
        .MSHR_DEPTH(MSHR_DEPTH),
        .BADDR_BITS(BADDR_BITS),
        .TAG_BITS  (TAG_BITS),
        .BLOCK_BITS(BLOCK_BITS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .miss_valid      (miss_valid),
        .miss_addr       (miss_addr),
        .miss_ready      (miss_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_accepted(mem_req_accepted),
        .current_req_tag (current_req_tag),
        .mem_data        (mem_data),
        .mem_data_tag    (mem_data_tag),
        .fill_valid      (fill_valid),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .mshr_count      (mshr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        miss_valid       = 1'b0;
        miss_addr        = '0;
        mem_req_accepted = 1'b0;
        current_req_tag  = '0;
        mem_data         = '0;
        mem_data_tag     = '0;
    endtask

    task automatic send_miss(input logic [BADDR_BITS-1:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        tick();
        idle_inputs();
    endtask

    task automatic grant(input logic [TAG_BITS-1:0] t);
        mem_req_accepted = 1'b1;
        current_req_tag  = t;
        tick();
        idle_inputs();
    endtask

    task automatic respond(input logic [TAG_BITS-1:0] t, input logic [63:0] d);
        mem_data_tag = t;
        mem_data     = d;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        miss_valid = 1'b1;
        miss_addr  = 29'h100;
        tick();
        tick();
        check("rst_count", 64'(mshr_count), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_fill_addr", 64'(fill_addr), 64'd0);
        check("rst_fill_data", fill_data, 64'd0);
        check("rst_miss_ready", 64'(miss_ready), 64'd0);
        idle_inputs();
        reset = 1'b1;
        tick();

        // Single miss round trip
        miss_valid = 1'b1;
        miss_addr  = 29'h100;
        #1;
        check("t1_miss_ready", 64'(miss_ready), 64'd1);
        tick();
        idle_inputs();
        check("t1_req_valid", 64'(mem_req_valid), 64'd1);
        check("t1_req_addr", 64'(mem_req_addr), 64'h100);
        check("t1_count", 64'(mshr_count), 64'd1);
        grant(4'd3);
        check("t1_req_gone", 64'(mem_req_valid), 64'd0);
        respond(4'd3, 64'hDEAD_BEEF);
        check("t1_fill_valid", 64'(fill_valid), 64'd1);
        check("t1_fill_addr", 64'(fill_addr), 64'h100);
        check("t1_fill_data", fill_data, 64'hDEAD_BEEF);
        check("t1_count_end", 64'(mshr_count), 64'd0);
        tick();
        check("t1_fill_pulse", 64'(fill_valid), 64'd0);
        check("t1_fill_hold", fill_data, 64'hDEAD_BEEF);

        // Fill all entries, then back-pressure
        for (int i = 0; i < 4; i++)
            send_miss(29'h10 + 29'(i));
        check("t2_count_full", 64'(mshr_count), 64'd4);
        miss_valid = 1'b1;
        miss_addr  = 29'h14;
        #1;
        check("t2_ready_full", 64'(miss_ready), 64'd0);
        tick();
        idle_inputs();
        check("t2_count_nochg", 64'(mshr_count), 64'd4);
        check("t2_head_addr", 64'(mem_req_addr), 64'h10);
        grant(4'd5);
        check("t2_head_next", 64'(mem_req_addr), 64'h11);
        // Response cycle: the free is not yet visible to miss_ready
        mem_data_tag = 4'd5;
        mem_data     = 64'h55;
        miss_valid   = 1'b1;
        miss_addr    = 29'h14;
        #1;
        check("t2_ready_samecyc", 64'(miss_ready), 64'd0);
        tick();
        idle_inputs();
        miss_valid = 1'b1;
        miss_addr  = 29'h14;
        #1;
        check("t2_fill_addr", 64'(fill_addr), 64'h10);
        check("t2_fill_data", fill_data, 64'h55);
        check("t2_count_3", 64'(mshr_count), 64'd3);
        check("t2_ready_after", 64'(miss_ready), 64'd1);
        idle_inputs();

        // Out-of-order return, with a grant and a response in the same cycle
        grant(4'd1);
        grant(4'd2);
        mem_req_accepted = 1'b1;
        current_req_tag  = 4'd4;
        mem_data_tag     = 4'd2;
        mem_data         = 64'hB0B;
        tick();
        idle_inputs();
        check("t3_fill_b_vld", 64'(fill_valid), 64'd1);
        check("t3_fill_b_addr", 64'(fill_addr), 64'h12);
        check("t3_fill_b_data", fill_data, 64'hB0B);
        check("t3_all_issued", 64'(mem_req_valid), 64'd0);
        check("t3_count_2", 64'(mshr_count), 64'd2);
        respond(4'd1, 64'hA0A);
        check("t3_fill_a_addr", 64'(fill_addr), 64'h11);
        check("t3_fill_a_data", fill_data, 64'hA0A);
        respond(4'd4, 64'hC0C);
        check("t3_fill_c_addr", 64'(fill_addr), 64'h13);
        check("t3_count_0", 64'(mshr_count), 64'd0);

        // Duplicate miss to an outstanding block
        send_miss(29'h40);
        grant(4'd6);
        miss_valid = 1'b1;
        miss_addr  = 29'h40;
        #1;
        check("t4_ready_dup", 64'(miss_ready), 64'd1);
        tick();
        idle_inputs();
`ifdef DCACHE_MSHR_MERGE_EN
        check("t4_merge_count", 64'(mshr_count), 64'd1);
        check("t4_merge_noreq", 64'(mem_req_valid), 64'd0);
        respond(4'd6, 64'h4040);
        check("t4_merge_fill", 64'(fill_valid), 64'd1);
        check("t4_merge_faddr", 64'(fill_addr), 64'h40);
        check("t4_merge_cnt0", 64'(mshr_count), 64'd0);
        tick();
        check("t4_merge_onefill", 64'(fill_valid), 64'd0);
`else
        check("t4_dup_count", 64'(mshr_count), 64'd2);
        check("t4_dup_req", 64'(mem_req_valid), 64'd1);
        check("t4_dup_raddr", 64'(mem_req_addr), 64'h40);
        grant(4'd7);
        respond(4'd6, 64'h4040);
        check("t4_dup_fill1", 64'(fill_valid), 64'd1);
        check("t4_dup_faddr1", 64'(fill_addr), 64'h40);
        check("t4_dup_cnt1", 64'(mshr_count), 64'd1);
        respond(4'd7, 64'h4141);
        check("t4_dup_fill2", 64'(fill_valid), 64'd1);
        check("t4_dup_fdata2", fill_data, 64'h4141);
        check("t4_dup_cnt0", 64'(mshr_count), 64'd0);
`endif

        // Zero-tag grant and unmatched responses
        send_miss(29'h200);
        grant(4'd0);
        check("t5_tag0_req", 64'(mem_req_valid), 64'd1);
        check("t5_tag0_addr", 64'(mem_req_addr), 64'h200);
        grant(4'd8);
        check("t5_issued", 64'(mem_req_valid), 64'd0);
        respond(4'd7, 64'h777);
        check("t5_nomatch_fv", 64'(fill_valid), 64'd0);
        check("t5_nomatch_hold", 64'(fill_addr), 64'h40);
        check("t5_nomatch_cnt", 64'(mshr_count), 64'd1);
        respond(4'd8, 64'h888);
        check("t5_fill_addr", 64'(fill_addr), 64'h200);
        check("t5_fill_data", fill_data, 64'h888);
        respond(4'd7, 64'h999);
        check("t5_idle_resp_fv", 64'(fill_valid), 64'd0);

        // Reset in the middle of operation
        send_miss(29'h300);
        send_miss(29'h301);
        grant(4'd9);
        check("t6_count_2", 64'(mshr_count), 64'd2);
        reset = 1'b0;
        #1;
        check("t6_rst_count", 64'(mshr_count), 64'd0);
        check("t6_rst_req", 64'(mem_req_valid), 64'd0);
        check("t6_rst_fdata", fill_data, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        respond(4'd9, 64'hABC);
        check("t6_stale_fv", 64'(fill_valid), 64'd0);
        check("t6_stale_cnt", 64'(mshr_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
Miss Status Holding Register file that sits between the D-cache and the memory arbiter. It accepts block-miss requests from the D-cache, issues them to memory in allocation order, and tracks the returned memory tags. When a matching tagged response arrives, it presents the fill (block address plus data) back to the D-cache for line write. Multiple misses may be outstanding, and responses may return out of order.

Parameters:
MSHR_DEPTH, 4, number of outstanding-miss entries (power of two, >=2)
BADDR_BITS, 29, block address width (byte address [31:3])
TAG_BITS, 4, memory transaction tag width; tag value 0 means "no transaction"
BLOCK_BITS, 64, memory block width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
miss_valid  input  1  D-cache presents a block miss this cycle
miss_addr  input  BADDR_BITS  missing block address
miss_ready  output  1  miss is accepted this cycle when miss_valid is also high
mem_req_valid  output  1  request pending toward the arbiter
mem_req_addr  output  BADDR_BITS  block address of the pending request
mem_req_accepted  input  1  arbiter granted the request this cycle
current_req_tag  input  TAG_BITS  tag memory assigned to the granted request (same cycle)
mem_data  input  BLOCK_BITS  response data
mem_data_tag  input  TAG_BITS  response tag; 0 means no response
fill_valid  output  1  fill available to the D-cache (one-cycle pulse per entry)
fill_addr  output  BADDR_BITS  block address of the fill
fill_data  output  BLOCK_BITS  block data of the fill
mshr_count  output  $clog2(MSHR_DEPTH+1)  number of occupied entries

Behaviour:
- Each entry holds state {FREE, WAIT_ISSUE, WAIT_DATA}, addr, and tag. A separate issue FIFO of entry indices (depth MSHR_DEPTH) records allocation order.
- Reset asserted (reset==0): all entries go to FREE and the issue FIFO is emptied. Outputs: mem_req_valid=0, fill_valid=0, fill_addr=0, fill_data=0, mshr_count=0, miss_ready=0 (forced low while in reset).
- miss_ready = (mshr_count < MSHR_DEPTH) || merge hit. It is combinational from registered state and the miss_addr compare. It does not consider frees occurring in the same cycle.
- Allocation: on miss_valid && miss_ready with no merge hit, the lowest-index FREE entry goes to WAIT_ISSUE with addr=miss_addr, and its index is pushed into the issue FIFO. Count increments at the edge.
- Merge hit: miss_addr equals addr of any entry in WAIT_ISSUE or WAIT_DATA. The miss is accepted with no allocation and no count change.
- Issue: mem_req_valid = issue FIFO non-empty. mem_req_addr = addr of the FIFO head entry. Both are combinational from registers.
  - On mem_req_accepted && current_req_tag!=0: the head entry goes to WAIT_DATA with tag=current_req_tag, and the FIFO pops.
  - mem_req_accepted with tag 0 is treated as not accepted; the request is retried next cycle.
- Response: if mem_data_tag!=0 matches the tag of an entry that was in WAIT_DATA at the start of the cycle, then at the next edge:
  - fill_valid=1, fill_addr=entry.addr, fill_data=mem_data;
  - the entry goes to FREE and count decrements.
  - Latency is 1 cycle from response to fill.
- No matching tag, or tag 0: fill_valid=0 next cycle, and fill_addr/fill_data hold their previous values. The response is ignored.
- fill_valid is a single-cycle pulse. The D-cache must take the fill unconditionally; there is no back-pressure on fill.
- Simultaneous events in one cycle (allocate, issue-accept, response) are all legal.
  - Count updates by +alloc −free.
  - A slot freed this cycle is not allocatable until the next cycle.
  - A response cannot match the entry being accepted in the same cycle.
- Miss arriving in the same cycle fill_valid is high, to that fill_addr: the entry is already FREE, so it allocates a new entry. The D-cache is responsible for suppressing this using the fill.
- Mid-operation reset drops all entries and the issue FIFO immediately. Responses returning after reset deasserts match nothing and are ignored.

Optional Feature:
DCACHE_MSHR_MERGE_EN
- Defined: duplicate-address merging as described above.
- Undefined: no address compare. miss_ready = (mshr_count < MSHR_DEPTH). Every accepted miss allocates an entry and issues its own memory request, even for an address already outstanding. Each response produces its own fill.

Test Plan:
- Reset, then a single miss 0x100 → mem_req_valid=1 and addr=0x100 the next cycle. Accept with tag 3 → mem_req_valid=0. Response tag 3 with data 0xDEAD_BEEF → one cycle later fill_valid=1, fill_addr=0x100, fill_data=0xDEAD_BEEF, then mshr_count returns to 0.
- Fill with 4 misses (0x10–0x13), no grants → mshr_count=4, miss_ready=0, a 5th miss 0x14 not accepted. Grant plus response for one entry → miss_ready=1 the cycle after the fill.
- Out-of-order return: misses A and B get tags 1 and 2; respond tag 2 then tag 1 → fills appear B then A, each with the correct data.
- With MERGE_EN: miss 0x40 twice while in WAIT_DATA → mshr_count=1, one memory request, one fill. Without MERGE_EN → two requests, two fills, mshr_count peaks at 2.
- Grant with current_req_tag=0 → entry stays WAIT_ISSUE and mem_req_valid stays 1. Response tag 7 with nothing outstanding → fill_valid stays 0.
- Two outstanding entries, then assert reset mid-operation → mshr_count=0 and mem_req_valid=0 immediately. A later response with an old tag → fill_valid=0.
